reg_bus_master: RTL and testbench

- Initiator for the 16-bit word register/memory slave interface (W, ON, ADDR, DATA_IN, DATA_OUT) used across the CPU datapath.
- Accepts single or burst read/write requests from the core over a REQ/BUSY handshake, then sequences the slave strobes one word per cycle.
- Returns read words with a valid strobe and pulls write words with a ready/valid handshake.
- Sits between the control unit and any slave of that kind, as its only driver.

---
 rtl/reg_bus_pkg.sv | 21 ++
 rtl/reg_burst_counter.sv | 70 +++++++
 rtl/reg_bus_master.sv | 163 ++++++++++++++++
 tb/tb_reg_bus_master.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// -----------------------------------------------------------------------------
// reg_bus_pkg
// Shared definitions for the register/memory slave bus initiator:
//   - master FSM state encoding
//   - default width constants for data word, slave address and burst length
// No ports; imported by reg_burst_counter and reg_bus_master.
// -----------------------------------------------------------------------------
package reg_bus_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 4;
  localparam int LEN_SIZE  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage : reg_bus_pkg

// File: rtl/reg_burst_counter.sv
// -----------------------------------------------------------------------------
// reg_burst_counter
// Address / remaining-beat tracker for one burst.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   load              capture load_addr / load_count (takes priority over step)
//   load_addr         burst start address
//   load_count        beats minus one
//   step              one beat transferred: addr+1 (wrapping), count-1
//   addr              current slave address
//   count             beats remaining minus one
//   last              current beat is the final one (count == 0)
// -----------------------------------------------------------------------------
module reg_burst_counter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_SIZE = reg_bus_pkg::ADDR_SIZE,
  parameter int LEN_SIZE  = reg_bus_pkg::LEN_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [ADDR_SIZE-1:0] load_addr,
  input  logic [LEN_SIZE-1:0]  load_count,
  input  logic                 step,
  output logic [ADDR_SIZE-1:0] addr,
  output logic [LEN_SIZE-1:0]  count,
  output logic                 last
);

  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [LEN_SIZE-1:0]  count_q, count_d;

  // Next address/count: load wins; a step on the last beat keeps count at
  // zero so it never underflows into a stale non-zero value.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    if (load) begin
      addr_d  = load_addr;
      count_d = load_count;
    end else if (step) begin
      addr_d = addr_q + ADDR_SIZE'(1);
      if (count_q == LEN_SIZE'(0)) begin
        count_d = count_q;
      end else begin
        count_d = count_q - LEN_SIZE'(1);
      end
    end else begin
      addr_d  = addr_q;
      count_d = count_q;
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= ADDR_SIZE'(0);
      count_q <= LEN_SIZE'(0);
    end else begin
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  assign addr  = addr_q;
  assign count = count_q;
  assign last  = (count_q == LEN_SIZE'(0));

endmodule : reg_burst_counter

// File: rtl/reg_bus_master.sv
// -----------------------------------------------------------------------------
// reg_bus_master
// Sole initiator for a word-wide register/memory slave (W, ON, ADDR, DATA_IN,
// DATA_OUT). Accepts a single or burst request in IDLE, then issues one slave
// access per cycle (reads free-running, writes paced by WR_VALID).
// Ports:
//   CLK, RST                     clock, asynchronous active-high reset
//   REQ, REQ_WR, REQ_ADDR,
//   REQ_LEN                      request (sampled in IDLE only), len = beats-1
//   BUSY, DONE                   burst in progress / one-cycle completion pulse
//   WR_DATA, WR_VALID, WR_READY  write-word handshake
//   RD_DATA, RD_VALID            registered read word and its valid strobe
//   MEM_W, MEM_ON, MEM_ADDR,
//   MEM_WDATA, MEM_RDATA         slave strobes and data
// -----------------------------------------------------------------------------
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int WORD_SIZE = reg_bus_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = reg_bus_pkg::ADDR_SIZE,
  parameter int LEN_SIZE  = reg_bus_pkg::LEN_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ,
  input  logic                 REQ_WR,
  input  logic [ADDR_SIZE-1:0] REQ_ADDR,
  input  logic [LEN_SIZE-1:0]  REQ_LEN,
  output logic                 BUSY,
  output logic                 DONE,
  input  logic [WORD_SIZE-1:0] WR_DATA,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  output logic [WORD_SIZE-1:0] RD_DATA,
  output logic                 RD_VALID,
  output logic                 MEM_W,
  output logic                 MEM_ON,
  output logic [ADDR_SIZE-1:0] MEM_ADDR,
  output logic [WORD_SIZE-1:0] MEM_WDATA,
  input  logic [WORD_SIZE-1:0] MEM_RDATA
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  logic                 cnt_load;
  logic                 cnt_step;
  logic [ADDR_SIZE-1:0] cnt_addr;
  logic [LEN_SIZE-1:0]  cnt_count;
  logic                 cnt_last;

  logic                 busy_c;
  logic                 done_c;
  logic                 wr_ready_c;
  logic                 mem_w_c;
  logic                 mem_on_c;
  logic [ADDR_SIZE-1:0] mem_addr_c;
  logic [WORD_SIZE-1:0] mem_wdata_c;

  reg_burst_counter #(
    .ADDR_SIZE (ADDR_SIZE),
    .LEN_SIZE  (LEN_SIZE)
  ) u_counter (
    .clk        (CLK),
    .rst        (RST),
    .load       (cnt_load),
    .load_addr  (REQ_ADDR),
    .load_count (REQ_LEN),
    .step       (cnt_step),
    .addr       (cnt_addr),
    .count      (cnt_count),
    .last       (cnt_last)
  );

  // Next state, counter control and slave strobes. MEM_RDATA feeds the read
  // register only in RD, so a floating slave bus elsewhere never leaks in.
  always_comb begin
    state_d     = state_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    busy_c      = 1'b1;
    done_c      = 1'b0;
    wr_ready_c  = 1'b0;
    mem_w_c     = 1'b0;
    mem_on_c    = 1'b0;
    mem_addr_c  = ADDR_SIZE'(0);
    mem_wdata_c = WORD_SIZE'(0);
    case (state_q)
      IDLE: begin
        busy_c = 1'b0;
        if (REQ) begin
          cnt_load = 1'b1;
          state_d  = REQ_WR ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        mem_on_c   = 1'b1;
        mem_addr_c = cnt_addr;
        rd_data_d  = MEM_RDATA;
        rd_valid_d = 1'b1;
        cnt_step   = 1'b1;
        if (cnt_last) begin
          state_d = FIN;
        end else begin
          state_d = RD;
        end
      end
      WR: begin
        wr_ready_c  = 1'b1;
        mem_on_c    = WR_VALID;
        mem_w_c     = WR_VALID;
        mem_addr_c  = cnt_addr;
        mem_wdata_c = WR_DATA;
        if (WR_VALID) begin
          cnt_step = 1'b1;
          if (cnt_last) begin
            state_d = FIN;
          end else begin
            state_d = WR;
          end
        end else begin
          state_d = WR;
        end
      end
      FIN: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and read-return registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      rd_data_q  <= WORD_SIZE'(0);
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign BUSY      = busy_c;
  assign DONE      = done_c;
  assign WR_READY  = wr_ready_c;
  assign RD_DATA   = rd_data_q;
  assign RD_VALID  = rd_valid_q;
  assign MEM_W     = mem_w_c;
  assign MEM_ON    = mem_on_c;
  assign MEM_ADDR  = mem_addr_c;
  assign MEM_WDATA = mem_wdata_c;

endmodule : reg_bus_master

// File: tb/tb_reg_bus_master.sv
// -----------------------------------------------------------------------------
// tb_reg_bus_master
// Drives reg_bus_master against a 16-word slave memory. Expected read words
// and write effects come from a reference array updated with plain modulo
// arithmetic; expected timing comes from the burst-latency rules.
// -----------------------------------------------------------------------------
module tb_reg_bus_master;

  logic        clk;
  logic        rst;
  logic        req;
  logic        req_wr;
  logic [3:0]  req_addr;
  logic [3:0]  req_len;
  logic        busy;
  logic        done;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        mem_w;
  logic        mem_on;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  wire  [15:0] mem_rdata;

  // slave memory, bench preload port, reference model
  logic [15:0] smem    [16];
  logic [15:0] ref_mem [16];
  logic [15:0] wdat    [16];
  logic        pl_we;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  int n_tests = 0;
  int n_fail  = 0;

  reg_bus_master dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ       (req),
    .REQ_WR    (req_wr),
    .REQ_ADDR  (req_addr),
    .REQ_LEN   (req_len),
    .BUSY      (busy),
    .DONE      (done),
    .WR_DATA   (wr_data),
    .WR_VALID  (wr_valid),
    .WR_READY  (wr_ready),
    .RD_DATA   (rd_data),
    .RD_VALID  (rd_valid),
    .MEM_W     (mem_w),
    .MEM_ON    (mem_on),
    .MEM_ADDR  (mem_addr),
    .MEM_WDATA (mem_wdata),
    .MEM_RDATA (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave: combinational read output, high-Z unless reading; write on edge.
  assign mem_rdata = (mem_on && !mem_w) ? smem[mem_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_on && mem_w) smem[mem_addr] <= mem_wdata;
    else if (pl_we)      smem[pl_addr]  <= pl_data;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input int a, input logic [15:0] v);
    pl_we = 1'b1; pl_addr = 4'(a); pl_data = v;
    tick();
    pl_we = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, {16'h0, smem[i]}, {16'h0, ref_mem[i]});
  endtask

  // Read burst of len+1 beats; poke=1 pulses a write REQ mid-burst.
  task automatic do_read(input int addr, input int len, input bit poke);
    int n;
    logic [15:0] expq [$];
    n = len + 1;
    expq = {};
    for (int k = 0; k < n; k++) expq.push_back(ref_mem[(addr + k) % 16]);
    req = 1'b1; req_wr = 1'b0; req_addr = 4'(addr); req_len = 4'(len);
    tick();
    req = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      if (poke && c == 2) begin req = 1'b1; req_wr = 1'b1; req_addr = 4'(addr + 7); end
      if (poke && c == 3) begin req = 1'b0; req_wr = 1'b0; end
      #1;
      chk("rd_valid", {31'h0, rd_valid}, {31'h0, (c >= 2 && c <= n + 1)});
      if (c >= 2 && c <= n + 1) chk("rd_data", {16'h0, rd_data}, {16'h0, expq[c - 2]});
      chk("rd_done", {31'h0, done}, {31'h0, (c == n + 1)});
      chk("rd_busy", {31'h0, busy}, {31'h0, (c <= n + 1)});
      chk("rd_on", {31'h0, mem_on}, {31'h0, (c <= n)});
      chk("rd_w", {31'h0, mem_w}, 32'h0);
      chk("rd_ready", {31'h0, wr_ready}, 32'h0);
      if (c <= n) chk("rd_addr", {28'h0, mem_addr}, 32'((addr + c - 1) % 16));
      if (c < n + 2) tick();
    end
  endtask

  // Write burst using wdat[0..len]; sc idle cycles inserted before beat sb.
  task automatic do_write(input int addr, input int len, input int sb, input int sc);
    int n;
    int stalls;
    n = len + 1;
    stalls = (sb < n) ? sc : 0;
    req = 1'b1; req_wr = 1'b1; req_addr = 4'(addr); req_len = 4'(len);
    tick();
    req = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k == sb) begin
        for (int s = 0; s < sc; s++) begin
          wr_valid = 1'b0; wr_data = 16'(($urandom));
          #1;
          chk("wr_stall_on", {31'h0, mem_on}, 32'h0);
          chk("wr_stall_w", {31'h0, mem_w}, 32'h0);
          chk("wr_stall_ready", {31'h0, wr_ready}, 32'h1);
          chk("wr_stall_done", {31'h0, done}, 32'h0);
          tick();
        end
      end
      wr_valid = 1'b1; wr_data = wdat[k];
      #1;
      chk("wr_ready", {31'h0, wr_ready}, 32'h1);
      chk("wr_on", {31'h0, mem_on}, 32'h1);
      chk("wr_w", {31'h0, mem_w}, 32'h1);
      chk("wr_addr", {28'h0, mem_addr}, 32'((addr + k) % 16));
      chk("wr_wdata", {16'h0, mem_wdata}, {16'h0, wdat[k]});
      chk("wr_busy", {31'h0, busy}, 32'h1);
      chk("wr_done_early", {31'h0, done}, 32'h0);
      tick();
    end
    wr_valid = 1'b0;
    #1;
    // cycle n+1+stalls: completion
    chk("wr_done", {31'h0, done}, 32'h1);
    chk("wr_fin_busy", {31'h0, busy}, 32'h1);
    chk("wr_fin_on", {31'h0, mem_on}, 32'h0);
    chk("wr_fin_rdv", {31'h0, rd_valid}, 32'h0);
    tick();
    #1;
    chk("wr_idle_busy", {31'h0, busy}, 32'h0);
    chk("wr_idle_done", {31'h0, done}, 32'h0);
    for (int k = 0; k < n; k++) ref_mem[(addr + k) % 16] = wdat[k];
    check_mem("wr_mem");
    if (stalls < 0) chk("wr_stalls", 32'(stalls), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_wr = 1'b0; req_addr = 4'h0; req_len = 4'h0;
    wr_data = 16'h0; wr_valid = 1'b0; pl_we = 1'b0; pl_addr = 4'h0; pl_data = 16'h0;
    @(negedge clk);
    @(negedge clk);
    // reset values
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_rdv", {31'h0, rd_valid}, 32'h0);
    chk("rst_w", {31'h0, mem_w}, 32'h0);
    chk("rst_on", {31'h0, mem_on}, 32'h0);
    chk("rst_rdata", {16'h0, rd_data}, 32'h0);
    chk("rst_addr", {28'h0, mem_addr}, 32'h0);
    chk("rst_wdata", {16'h0, mem_wdata}, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) preload(i, 16'($urandom));
    preload(3, 16'hBEEF);

    // single read
    do_read(3, 0, 1'b0);
    chk("single_rd_data_hold", {16'h0, rd_data}, 32'h0000BEEF);

    // write burst with address wrap
    wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333;
    do_write(14, 2, 99, 0);
    chk("wrap_e", {16'h0, smem[14]}, 32'h00001111);
    chk("wrap_f", {16'h0, smem[15]}, 32'h00002222);
    chk("wrap_0", {16'h0, smem[0]}, 32'h00003333);

    // same burst, stalled two cycles before beat 2
    wdat[0] = 16'hA1A1; wdat[1] = 16'hB2B2; wdat[2] = 16'hC3C3;
    do_write(14, 2, 2, 2);

    // full 16-beat read from 0
    do_read(0, 15, 1'b0);

    // REQ during a burst is ignored; next REQ after DONE accepted
    do_read(5, 4, 1'b1);
    do_read(9, 1, 1'b0);

    // reset mid-write: strobe drops at once, slave untouched, no DONE
    req = 1'b1; req_wr = 1'b1; req_addr = 4'h5; req_len = 4'h1;
    tick();
    req = 1'b0; wr_valid = 1'b1; wr_data = ~ref_mem[5];
    #1;
    chk("mid_rst_on_before", {31'h0, mem_on}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_on", {31'h0, mem_on}, 32'h0);
    chk("mid_rst_w", {31'h0, mem_w}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_mem5", {16'h0, smem[5]}, {16'h0, ref_mem[5]});
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    #1;
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_ready", {31'h0, wr_ready}, 32'h0);
    check_mem("post_rst_mem");

    // randomized bursts
    for (int r = 0; r < 10; r++) begin
      int a, l, sb, sc;
      a = int'($urandom_range(0, 15));
      l = int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) wdat[k] = 16'($urandom);
        sb = int'($urandom_range(0, 16));
        sc = int'($urandom_range(0, 3));
        do_write(a, l, sb, sc);
      end else begin
        do_read(a, l, 1'b0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_bus_master
